// File: rtl/decode_cycle_if.sv
// -----------------------------------------------------------------------------
// decode_cycle_if
//   Bundle of the decode-stage bus: fetch-stage inputs (InstrD, PCD, PCPlus4D),
//   the write-back port (RegWriteW, RDW, ResultW) and the registered
//   execute-stage outputs (*E / *_E).
//   Modports:
//     master -- drives the decode inputs, observes the execute outputs
//     slave  -- the decode stage itself
//   Optional macro DECODE_FLUSH_EN adds FlushE (bubble insertion into ID/EX).
// -----------------------------------------------------------------------------
interface decode_cycle_if #(
  parameter int XLEN = 32
);
  // Fetch / write-back side
  logic [XLEN-1:0] InstrD;
  logic [XLEN-1:0] PCD;
  logic [XLEN-1:0] PCPlus4D;
  logic            RegWriteW;
  logic [4:0]      RDW;
  logic [XLEN-1:0] ResultW;
`ifdef DECODE_FLUSH_EN
  logic            FlushE;
`endif

  // Execute side
  logic            RegWriteE;
  logic            ALUSrcE;
  logic            MemWriteE;
  logic            ResultSrcE;
  logic            BranchE;
  logic [2:0]      ALUControlE;
  logic [XLEN-1:0] RD1_E;
  logic [XLEN-1:0] RD2_E;
  logic [XLEN-1:0] Imm_Ext_E;
  logic [XLEN-1:0] PCE;
  logic [XLEN-1:0] PCPlus4E;
  logic [4:0]      RD_E;
  logic [4:0]      RS1_E;
  logic [4:0]      RS2_E;

  modport master (
`ifdef DECODE_FLUSH_EN
    output FlushE,
`endif
    output InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW,
    input  RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
    input  RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E, RS1_E, RS2_E
  );

  modport slave (
`ifdef DECODE_FLUSH_EN
    input  FlushE,
`endif
    input  InstrD, PCD, PCPlus4D, RegWriteW, RDW, ResultW,
    output RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
    output RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, RD_E, RS1_E, RS2_E
  );
endinterface

// File: rtl/decode_cycle.sv
// -----------------------------------------------------------------------------
// decode_cycle
//   RV32I-subset decode stage: main/ALU decoder, immediate sign-extension,
//   32x32 register file with write-back bypass, and the ID/EX pipeline register.
//   Ports:
//     clk  -- single clock, rising edge
//     rst  -- asynchronous, active-low reset; clears ID/EX and the register file
//             and forces every output to 0 while low
//     bus  -- decode_cycle_if.slave (fetch inputs, write-back port, *_E outputs)
//   Optional macro DECODE_FLUSH_EN: adds FlushE; when high at a rising edge the
//   ID/EX register loads a bubble. Register-file writes are never affected.
//   Only XLEN = 32 is supported.
// -----------------------------------------------------------------------------
module decode_cycle #(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          rst,
  decode_cycle_if.slave bus
);

  typedef enum logic [6:0] {
    OP_LW  = 7'b0000011,
    OP_SW  = 7'b0100011,
    OP_R   = 7'b0110011,
    OP_I   = 7'b0010011,
    OP_BEQ = 7'b1100011
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_e;

  typedef struct packed {
    logic            reg_write;
    logic            alu_src;
    logic            mem_write;
    logic            result_src;
    logic            branch;
    logic [2:0]      alu_ctrl;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
  } idex_t;

  // R/I arithmetic share one funct3 table; only R-type honours funct7[5].
  function automatic logic [2:0] alu_from_funct3(input logic [2:0] f3,
                                                  input logic       sub);
    logic [2:0] op;
    case (f3)
      3'b000:  op = sub ? ALU_SUB : ALU_ADD;
      3'b010:  op = ALU_SLT;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  logic [XLEN-1:0] instr;
  logic [4:0]      rs1_a;
  logic [4:0]      rs2_a;
  logic [XLEN-1:0] rf_q [32];
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  idex_t           idex_d;
  idex_t           idex_q;
  idex_t           out_s;

  assign instr = bus.InstrD;
  assign rs1_a = instr[19:15];
  assign rs2_a = instr[24:20];

  assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_s = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25],
                  instr[11:8], 1'b0};

  // ---------------------------------------------------------------------------
  // Register file. x0 is never written and always reads as zero. A register
  // being written back this cycle is forwarded so decode sees the new value.
  // ---------------------------------------------------------------------------
  // NOTE: every entry is cleared by the async reset, so the array cannot map to
  // a RAM macro; that is intended -- post-reset reads must return 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (bus.RegWriteW && (bus.RDW != 5'd0)) begin
      // NOTE: non-blocking so every flop samples pre-edge values; blocking here
      // would make the order of always blocks change behaviour.
      rf_q[bus.RDW] <= bus.ResultW;
    end
  end

  always_comb begin
    if (rs1_a == 5'd0)                              rd1 = '0;
    else if (bus.RegWriteW && (bus.RDW == rs1_a))   rd1 = bus.ResultW;
    else                                            rd1 = rf_q[rs1_a];

    if (rs2_a == 5'd0)                              rd2 = '0;
    else if (bus.RegWriteW && (bus.RDW == rs2_a))   rd2 = bus.ResultW;
    else                                            rd2 = rf_q[rs2_a];
  end

  // ---------------------------------------------------------------------------
  // Decode into the next ID/EX value. Unknown opcodes leave the control and
  // immediate fields at zero, i.e. a bubble.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: the whole struct gets a default first, so no path leaves a field
    // unassigned and no latch is inferred.
    idex_d          = '0;
    idex_d.rd1      = rd1;
    idex_d.rd2      = rd2;
    idex_d.pc       = bus.PCD;
    idex_d.pc_plus4 = bus.PCPlus4D;
    idex_d.rd       = instr[11:7];
    idex_d.rs1      = rs1_a;
    idex_d.rs2      = rs2_a;

    case (instr[6:0])
      OP_LW: begin
        idex_d.reg_write  = 1'b1;
        idex_d.alu_src    = 1'b1;
        idex_d.result_src = 1'b1;
        idex_d.alu_ctrl   = ALU_ADD;
        idex_d.imm        = imm_i;
      end
      OP_SW: begin
        idex_d.alu_src    = 1'b1;
        idex_d.mem_write  = 1'b1;
        idex_d.alu_ctrl   = ALU_ADD;
        idex_d.imm        = imm_s;
      end
      OP_R: begin
        idex_d.reg_write  = 1'b1;
        idex_d.alu_ctrl   = alu_from_funct3(instr[14:12], instr[30]);
      end
      OP_I: begin
        idex_d.reg_write  = 1'b1;
        idex_d.alu_src    = 1'b1;
        idex_d.alu_ctrl   = alu_from_funct3(instr[14:12], 1'b0);
        idex_d.imm        = imm_i;
      end
      OP_BEQ: begin
        idex_d.branch     = 1'b1;
        idex_d.alu_ctrl   = ALU_SUB;
        idex_d.imm        = imm_b;
      end
      default: ;
    endcase

`ifdef DECODE_FLUSH_EN
    if (bus.FlushE) idex_d = '0;
`endif
  end

  // ID/EX pipeline register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) idex_q <= '0;
    else      idex_q <= idex_d;
  end

  // Outputs are held at zero for the whole time reset is low, regardless of
  // what the registers contain.
  assign out_s = rst ? idex_q : '0;

  assign bus.RegWriteE   = out_s.reg_write;
  assign bus.ALUSrcE     = out_s.alu_src;
  assign bus.MemWriteE   = out_s.mem_write;
  assign bus.ResultSrcE  = out_s.result_src;
  assign bus.BranchE     = out_s.branch;
  assign bus.ALUControlE = out_s.alu_ctrl;
  assign bus.RD1_E       = out_s.rd1;
  assign bus.RD2_E       = out_s.rd2;
  assign bus.Imm_Ext_E   = out_s.imm;
  assign bus.PCE         = out_s.pc;
  assign bus.PCPlus4E    = out_s.pc_plus4;
  assign bus.RD_E        = out_s.rd;
  assign bus.RS1_E       = out_s.rs1;
  assign bus.RS2_E       = out_s.rs2;

endmodule

// File: tb/tb_decode_cycle.sv
// -----------------------------------------------------------------------------
// tb_decode_cycle
//   Drives decode_cycle through its interface: reset, directed instructions
//   with hand-computed expectations, then randomized instructions, write-backs
//   (and flushes when DECODE_FLUSH_EN is defined) with a mid-stream reset.
//   A reference model (array register file + instruction-semantics decode)
//   predicts the *_E outputs for every edge; one process compares them.
// -----------------------------------------------------------------------------
module tb_decode_cycle;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decode_cycle_if bus ();

  decode_cycle #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        rw, as, mw, rs, br;
    logic [2:0]  alu;
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rd, rs1, rs2;
  } exp_t;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] ref_rf [32];
  exp_t        exp_q;
  bit          exp_valid = 1'b0;
  bit          flush_v   = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t sample_dut();
    exp_t a;
    a.rw  = bus.RegWriteE;  a.as  = bus.ALUSrcE;   a.mw = bus.MemWriteE;
    a.rs  = bus.ResultSrcE; a.br  = bus.BranchE;   a.alu = bus.ALUControlE;
    a.rd1 = bus.RD1_E;      a.rd2 = bus.RD2_E;     a.imm = bus.Imm_Ext_E;
    a.pc  = bus.PCE;        a.pc4 = bus.PCPlus4E;
    a.rd  = bus.RD_E;       a.rs1 = bus.RS1_E;     a.rs2 = bus.RS2_E;
    return a;
  endfunction

  task automatic compare_all(input exp_t a, input exp_t e);
    check("RegWriteE",   32'(a.rw),  32'(e.rw));
    check("ALUSrcE",     32'(a.as),  32'(e.as));
    check("MemWriteE",   32'(a.mw),  32'(e.mw));
    check("ResultSrcE",  32'(a.rs),  32'(e.rs));
    check("BranchE",     32'(a.br),  32'(e.br));
    check("ALUControlE", 32'(a.alu), 32'(e.alu));
    check("RD1_E",       a.rd1,      e.rd1);
    check("RD2_E",       a.rd2,      e.rd2);
    check("Imm_Ext_E",   a.imm,      e.imm);
    check("PCE",         a.pc,       e.pc);
    check("PCPlus4E",    a.pc4,      e.pc4);
    check("RD_E",        32'(a.rd),  32'(e.rd));
    check("RS1_E",       32'(a.rs1), 32'(e.rs1));
    check("RS2_E",       32'(a.rs2), 32'(e.rs2));
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_read(input logic [4:0] r, input bit we,
                                           input logic [4:0] wa,
                                           input logic [31:0] wd);
    if (r == 0)             return 32'd0;
    if (we && wa == r)      return wd;
    return ref_rf[r];
  endfunction

  // add/sub, slt, or, and -> encoded ALU operation
  function automatic logic [2:0] ref_alu(input logic [2:0] f3, input bit sub);
    case (f3)
      3'd0:    return sub ? 3'd1 : 3'd0;
      3'd2:    return 3'd5;
      3'd6:    return 3'd3;
      3'd7:    return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                 input bit rst_v, input bit fl, input bit we,
                                 input logic [4:0] wa, input logic [31:0] wd);
    exp_t e = '0;
    logic signed [11:0] i12 = ins[31:20];
    logic signed [11:0] s12 = {ins[31:25], ins[11:7]};
    logic signed [12:0] b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    if (!rst_v || fl) return e;
    e.rd1 = ref_read(ins[19:15], we, wa, wd);
    e.rd2 = ref_read(ins[24:20], we, wa, wd);
    e.pc  = pc;
    e.pc4 = pc + 32'd4;
    e.rd  = ins[11:7];
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    case (ins[6:0])
      7'h03: begin e.rw = 1; e.as = 1; e.rs = 1; e.imm = int'(i12); end
      7'h23: begin e.as = 1; e.mw = 1; e.imm = int'(s12); end
      7'h33: begin e.rw = 1; e.alu = ref_alu(ins[14:12], ins[30]); end
      7'h13: begin e.rw = 1; e.as = 1; e.alu = ref_alu(ins[14:12], 1'b0);
                   e.imm = int'(i12); end
      7'h63: begin e.br = 1; e.alu = 3'd1; e.imm = int'(b13); end
      default: ;
    endcase
    return e;
  endfunction

  // Apply one cycle of stimulus at the falling edge, predict, then take the
  // rising edge and update the reference register file.
  task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                       input bit rst_v, input bit fl, input bit we,
                       input logic [4:0] wa, input logic [31:0] wd);
    @(negedge clk);
    rst           = rst_v;
    bus.InstrD    = ins;
    bus.PCD       = pc;
    bus.PCPlus4D  = pc + 32'd4;
    bus.RegWriteW = we;
    bus.RDW       = wa;
    bus.ResultW   = wd;
    flush_v       = fl;
`ifdef DECODE_FLUSH_EN
    bus.FlushE    = fl;
`endif
`ifndef DECODE_FLUSH_EN
    // without the flush port the ID/EX register always loads decode results
    fl = 1'b0;
`endif
    exp_q     = model(ins, pc, rst_v, fl, we, wa, wd);
    exp_valid = 1'b1;
    @(posedge clk);
    if (!rst_v) for (int i = 0; i < 32; i++) ref_rf[i] = '0;
    else if (we && wa != 0) ref_rf[wa] = wd;
    #2;
  endtask

  // Single compare process: outputs checked 1 time unit after every rising edge.
  always @(posedge clk) begin
    #1;
    if (exp_valid) compare_all(sample_dut(), exp_q);
  end

  localparam logic [31:0] NOP = 32'h0000_0013;  // addi x0,x0,0

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins = $urandom;
    case ($urandom_range(0, 5))
      0: ins[6:0] = 7'h03;
      1: ins[6:0] = 7'h23;
      2: ins[6:0] = 7'h33;
      3: ins[6:0] = 7'h13;
      4: ins[6:0] = 7'h63;
      default: ;
    endcase
    return ins;
  endfunction

  initial begin
    exp_t z = '0;
    exp_t a;
    for (int i = 0; i < 32; i++) ref_rf[i] = '0;

    // Reset held with a valid I-type instruction on the input
    rst = 1'b0;
    bus.InstrD = 32'h0050_0093; bus.PCD = 32'h100; bus.PCPlus4D = 32'h104;
    bus.RegWriteW = 1'b0; bus.RDW = '0; bus.ResultW = '0;
`ifdef DECODE_FLUSH_EN
    bus.FlushE = 1'b0;
`endif
    #12;
    compare_all(sample_dut(), z);
    drive(32'h0050_0093, 32'h100, 0, 0, 1, 5'd1, 32'hFFFF_FFFF);
    drive(32'h0050_0093, 32'h100, 0, 0, 0, 5'd0, 32'd0);

    // First cycle after release: register file reads zero
    drive(32'h0062_83B3, 32'h200, 1, 0, 0, 5'd0, 32'd0);   // add x7,x5,x6
    check("post_reset_rd1", bus.RD1_E, 32'd0);
    check("post_reset_rd2", bus.RD2_E, 32'd0);

    // addi x2,x1,10 after writing x1=5
    drive(NOP, 32'h204, 1, 0, 1, 5'd1, 32'd5);
    drive(32'h00A0_8113, 32'h208, 1, 0, 0, 5'd0, 32'd0);
    check("addi_regwrite", 32'(bus.RegWriteE), 32'd1);
    check("addi_alusrc",   32'(bus.ALUSrcE), 32'd1);
    check("addi_rd1",      bus.RD1_E, 32'd5);
    check("addi_imm",      bus.Imm_Ext_E, 32'd10);
    check("addi_rd",       32'(bus.RD_E), 32'd2);
    check("addi_alu",      32'(bus.ALUControlE), 32'd0);

    // sub x4,x3,x3 with same-cycle write-back of x3
    drive(32'h4031_8233, 32'h20C, 1, 0, 1, 5'd3, 32'hDEAD_BEEF);
    check("bypass_rd1", bus.RD1_E, 32'hDEAD_BEEF);
    check("bypass_rd2", bus.RD2_E, 32'hDEAD_BEEF);
    check("bypass_alu", 32'(bus.ALUControlE), 32'd1);

    // write to x0 is dropped
    drive(NOP, 32'h210, 1, 0, 1, 5'd0, 32'h1234_5678);
    drive(32'h0010_0113, 32'h214, 1, 0, 0, 5'd0, 32'd0);   // addi x2,x0,1
    check("x0_rd1", bus.RD1_E, 32'd0);

    // branch / store immediates
    drive(32'hFE00_0EE3, 32'h218, 1, 0, 0, 5'd0, 32'd0);
    check("beq_branch", 32'(bus.BranchE), 32'd1);
    check("beq_imm",    bus.Imm_Ext_E, 32'hFFFF_FFFC);
    drive(32'h0020_A223, 32'h21C, 1, 0, 0, 5'd0, 32'd0);
    check("sw_memwrite", 32'(bus.MemWriteE), 32'd1);
    check("sw_imm",      bus.Imm_Ext_E, 32'd4);

    // lw with FlushE asserted (ignored when the port does not exist)
    drive(32'h0000_A183, 32'h220, 1, 1, 0, 5'd0, 32'd0);
`ifdef DECODE_FLUSH_EN
    a = sample_dut();
    check("flush_regwrite",  32'(a.rw), 32'd0);
    check("flush_resultsrc", 32'(a.rs), 32'd0);
    check("flush_pc",        a.pc,      32'd0);
    check("flush_rs1",       32'(a.rs1), 32'd0);
`else
    a = sample_dut();
    check("lw_regwrite",  32'(a.rw), 32'd1);
    check("lw_resultsrc", 32'(a.rs), 32'd1);
`endif

    // Randomized traffic with a mid-stream asynchronous reset
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins = rand_instr();
      bit          we  = $urandom_range(0, 1) == 1;
      logic [4:0]  wa  = $urandom_range(0, 1) == 1 ? ins[19:15] : 5'($urandom);
      bit          fl  = $urandom_range(0, 7) == 0;
      if (n == 200) begin
        exp_valid = 1'b0;
        rst = 1'b0;              // asserted between edges, outputs drop at once
        #1;
        compare_all(sample_dut(), z);
        drive(ins, $urandom, 0, 0, we, wa, $urandom);
      end
      drive(ins, $urandom, 1, fl, we, wa, $urandom);
    end

    @(negedge clk);
    exp_valid = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/decode_cycle.md
DECODE_CYCLE -- requirements
Module: decode_cycle

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports InstrD/PCD/PCPlus4D  input  32 each  instruction, PC and PC+4 from the fetch stage register.
REQ-005 SHALL have ports RegWriteW  input  1, RDW  input  5, ResultW  input  32: write-back enable, destination and data.
REQ-006 SHALL have registered outputs RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE (output, 1 each): execute-stage controls.
REQ-007 SHALL have registered output ALUControlE  output  3  ALU operation.
REQ-008 SHALL have registered outputs RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E  output  32 each.
REQ-009 SHALL have registered outputs RD_E, RS1_E, RS2_E  output  5 each: InstrD[11:7], [19:15], [24:20].

Function
REQ-010 SHALL decode opcode InstrD[6:0]: 0000011 lw, 0100011 sw, 0110011 R-type, 0010011 I-ALU, 1100011 beq.
REQ-011 SHALL set controls (RegWrite,ALUSrc,MemWrite,ResultSrc,Branch): lw 1,1,0,1,0; sw 0,1,1,0,0; R 1,0,0,0,0; I-ALU 1,1,0,0,0; beq 0,0,0,0,1.
REQ-012 SHALL derive ALUControl: lw/sw 000 add; beq 001 sub; R/I by funct3: 000 add (R with funct7[5]=1: 001 sub), 010 101 slt, 110 011 or, 111 010 and; other funct3 000.
REQ-013 SHALL treat any other opcode as a bubble: all controls 0, ALUControl 000.
REQ-014 SHALL sign-extend immediates: I {20x[31],[31:20]}; S {20x[31],[31:25],[11:7]}; B {19x[31],[31],[7],[30:25],[11:8],1'b0}; R-type/unknown 0.
REQ-015 SHALL contain a 32x32 register file; reads of x0 return 0; read ports combinational, indexed by InstrD[19:15] and [24:20].
REQ-016 SHALL write ResultW to register RDW on rising clk when RegWriteW=1 and RDW!=0; writes to x0 ignored.
REQ-017 SHALL bypass write-back: same-cycle read of a nonzero register being written returns ResultW.
REQ-018 SHALL register all decode results into the ID/EX register every rising clk; latency InstrD -> *_E outputs exactly one cycle.
REQ-019 SHALL pass PCD and PCPlus4D unchanged to PCE and PCPlus4E.

Reset
REQ-020 SHALL, while rst=0, asynchronously clear every ID/EX register and every register-file entry to 0.
REQ-021 SHALL drive every output to 0 combinationally while rst=0, independent of register state.
REQ-022 SHALL, on rst deassertion mid-stream, produce first valid *_E outputs one rising edge after InstrD is sampled.

Configuration
REQ-023 SHALL, with macro DECODE_FLUSH_EN defined, add port FlushE input 1: when 1 at a rising edge, the ID/EX register loads all zeros (bubble) instead of decode results; register-file writes proceed unaffected.
REQ-024 SHALL, without DECODE_FLUSH_EN, have no FlushE port; ID/EX register loads decode results on every edge.

Verification
REQ-025 SHALL verify reset: rst=0 with InstrD=0x00500093 -> all outputs 0; register file reads 0 after release.
REQ-026 SHALL verify I-ALU: write x1=5 via W port, then InstrD=0x00A08113 (addi x2,x1,10) -> next cycle RegWriteE=1, ALUSrcE=1, RD1_E=5, Imm_Ext_E=10, RD_E=2, ALUControlE=000.
REQ-027 SHALL verify bypass: RegWriteW=1, RDW=3, ResultW=0xDEADBEEF same cycle as InstrD=0x40318233 (sub x4,x3,x3) -> RD1_E=RD2_E=0xDEADBEEF, ALUControlE=001.
REQ-028 SHALL verify x0: RegWriteW=1, RDW=0, ResultW=0x12345678, then read x0 -> RD1_E=0.
REQ-029 SHALL verify branch/store immediates: InstrD=0xFE000EE3 (beq x0,x0,-4) -> BranchE=1, Imm_Ext_E=0xFFFFFFFC; InstrD=0x0020A223 (sw x2,4(x1)) -> MemWriteE=1, Imm_Ext_E=4.
REQ-030 SHALL verify flush (DECODE_FLUSH_EN): FlushE=1 with lw InstrD=0x0000A183 -> next cycle all *_E outputs 0; without macro same stimulus -> RegWriteE=1, ResultSrcE=1.
